// File: rtl/kernel_run_ctrl.sv
// kernel_run_ctrl
// Launch sequencer and dmem arbiter for one riscv_kernel instance.
//
// The host issues a run command. The block then:
//   - pulses the kernel start for START_CYCLES cycles,
//   - counts RUN cycles until the kernel reports done or the timeout expires,
//   - returns a status and cycle-count response.
// The kernel is parked under reset whenever the host owns the dmem port.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command; kernel parked; host owns dmem
// START | kernel start held high for START_CYCLES cycles
// RUN   | kernel running and owns dmem; counting cycles
// RESP  | response presented; kernel parked; host owns dmem
//
// Ports:
//   ap_clk, ap_rst                 clock, synchronous active-high reset
//   cmd_*                          run command (valid/ready, timeout, 0 = none)
//   rsp_*                          response (valid/ready, status, cycles)
//   busy                           state is START or RUN
//   k_ap_*                         kernel start/reset/done/idle
//   k_dmem_*                       kernel dmem request / read data
//   h_dmem_*                       host dmem request, grant, read-valid, data
//   dmem_*                         physical single-port dmem, 1-cycle read
module kernel_run_ctrl #(
  parameter int START_CYCLES      = 2,
  parameter int TIMEOUT_W         = 16,
  parameter int AddressWidth_dmem = 5,
  parameter int DataWidth         = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [TIMEOUT_W-1:0]         cmd_timeout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [1:0]                   rsp_status,
  output logic [31:0]                  rsp_cycles,
  output logic                         busy,
  output logic                         k_ap_start,
  output logic                         k_ap_rst,
  input  logic                         k_ap_done,
  input  logic                         k_ap_idle,
  input  logic [AddressWidth_dmem-1:0] k_dmem_address0,
  input  logic                         k_dmem_ce0,
  input  logic                         k_dmem_we0,
  input  logic [DataWidth-1:0]         k_dmem_d0,
  output logic [DataWidth-1:0]         k_dmem_q0,
  input  logic                         h_dmem_req,
  input  logic                         h_dmem_we,
  input  logic [AddressWidth_dmem-1:0] h_dmem_addr,
  input  logic [DataWidth-1:0]         h_dmem_d,
  output logic                         h_dmem_gnt,
  output logic                         h_dmem_rvalid,
  output logic [DataWidth-1:0]         h_dmem_q,
  output logic [AddressWidth_dmem-1:0] dmem_address0,
  output logic                         dmem_ce0,
  output logic                         dmem_we0,
  output logic [DataWidth-1:0]         dmem_d0,
  input  logic [DataWidth-1:0]         dmem_q0
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] START_LAST = 8'(START_CYCLES - 1);

  state_t               state_q, state_d;
  logic [7:0]           start_cnt_q, start_cnt_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [1:0]           status_q, status_d;
  logic                 rvalid_q;
  logic [31:0]          cnt_now;
  logic                 host_win;
  logic                 unused_idle;

  assign unused_idle = k_ap_idle;

  // Value of the counter "in" the current RUN cycle: the first RUN cycle reads 1.
  assign cnt_now = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      start_cnt_q <= '0;
      cnt_q       <= '0;
      timeout_q   <= '0;
      status_q    <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
      status_q    <= status_d;
      rvalid_q    <= h_dmem_gnt & ~h_dmem_we;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    status_d    = status_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          timeout_d   = cmd_timeout;
          cnt_d       = '0;
          start_cnt_d = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        start_cnt_d = start_cnt_q + 8'd1;
        if (start_cnt_q == START_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_now;
        if (k_ap_done) begin
          status_d = 2'b00;
          state_d  = S_RESP;
        end else if ((timeout_q != '0) && (cnt_now == 32'(timeout_q))) begin
          status_d = 2'b01;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q == S_START) || (state_q == S_RUN);
  assign k_ap_start = (state_q == S_START);
  assign k_ap_rst   = (state_q == S_IDLE) || (state_q == S_RESP);
  assign rsp_status = status_q;
  assign rsp_cycles = cnt_q;

  // The host owns dmem only while the kernel is parked under reset.
  assign host_win      = (state_q == S_IDLE) || (state_q == S_RESP);
  assign h_dmem_gnt    = host_win & h_dmem_req;
  assign h_dmem_rvalid = rvalid_q;

  assign dmem_address0 = h_dmem_gnt ? h_dmem_addr : k_dmem_address0;
  assign dmem_ce0      = h_dmem_gnt ? 1'b1        : k_dmem_ce0;
  assign dmem_we0      = h_dmem_gnt ? h_dmem_we   : k_dmem_we0;
  assign dmem_d0       = h_dmem_gnt ? h_dmem_d    : k_dmem_d0;
  assign k_dmem_q0     = dmem_q0;
  assign h_dmem_q      = dmem_q0;

endmodule

// File: tb/tb_kernel_run_ctrl.sv
module tb_kernel_run_ctrl;

  localparam int SC = 2;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        cmd_valid, cmd_ready;
  logic [15:0] cmd_timeout;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_cycles;
  logic        busy, k_ap_start, k_ap_rst, k_ap_done, k_ap_idle;
  logic [4:0]  k_dmem_address0;
  logic        k_dmem_ce0, k_dmem_we0;
  logic [31:0] k_dmem_d0, k_dmem_q0;
  logic        h_dmem_req, h_dmem_we, h_dmem_gnt, h_dmem_rvalid;
  logic [4:0]  h_dmem_addr;
  logic [31:0] h_dmem_d, h_dmem_q;
  logic [4:0]  dmem_address0;
  logic        dmem_ce0, dmem_we0;
  logic [31:0] dmem_d0, dmem_q0;

  logic [31:0] mem [0:31];

  int n_cmp = 0;
  int n_err = 0;

  kernel_run_ctrl #(.START_CYCLES(SC), .TIMEOUT_W(16),
                    .AddressWidth_dmem(5), .DataWidth(32)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_timeout(cmd_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_status(rsp_status), .rsp_cycles(rsp_cycles), .busy(busy),
    .k_ap_start(k_ap_start), .k_ap_rst(k_ap_rst),
    .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
    .k_dmem_address0(k_dmem_address0), .k_dmem_ce0(k_dmem_ce0),
    .k_dmem_we0(k_dmem_we0), .k_dmem_d0(k_dmem_d0), .k_dmem_q0(k_dmem_q0),
    .h_dmem_req(h_dmem_req), .h_dmem_we(h_dmem_we),
    .h_dmem_addr(h_dmem_addr), .h_dmem_d(h_dmem_d),
    .h_dmem_gnt(h_dmem_gnt), .h_dmem_rvalid(h_dmem_rvalid), .h_dmem_q(h_dmem_q),
    .dmem_address0(dmem_address0), .dmem_ce0(dmem_ce0), .dmem_we0(dmem_we0),
    .dmem_d0(dmem_d0), .dmem_q0(dmem_q0)
  );

  always #5 ap_clk = ~ap_clk;

  // physical dmem model: single port, 1-cycle read latency
  always @(posedge ap_clk) begin
    if (dmem_ce0) begin
      if (dmem_we0) mem[dmem_address0] <= dmem_d0;
      else          dmem_q0 <= mem[dmem_address0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Issue one command, optionally holding a host request through RUN, and
  // check the START pulse, the RUN length and the response fields.
  task automatic run_cmd(input logic [15:0] tmo, input int done_at,
                         input logic [1:0] exp_st, input int exp_cyc,
                         input bit host_block);
    int n_start;
    int r;
    cmd_valid   = 1'b1;
    cmd_timeout = tmo;
    tick();
    cmd_valid = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_krst", 32'(k_ap_rst), 32'd0);
    n_start = 0;
    while (k_ap_start && n_start < 50) begin
      n_start++;
      tick();
    end
    chk("start_len", 32'(n_start), 32'(SC));
    if (host_block) begin
      h_dmem_req  = 1'b1;  h_dmem_we = 1'b1;
      h_dmem_addr = 5'd7;  h_dmem_d  = 32'h0000_0055;
      k_dmem_address0 = 5'd9; k_dmem_ce0 = 1'b1;
      k_dmem_we0 = 1'b1;      k_dmem_d0  = 32'h0000_1234;
      #1;
      chk("run_gnt", 32'(h_dmem_gnt), 32'd0);
      chk("run_addr", 32'(dmem_address0), 32'd9);
      chk("run_d", dmem_d0, 32'h0000_1234);
      chk("run_we", 32'(dmem_we0), 32'd1);
    end
    r = 0;
    while (!rsp_valid && r < 100) begin
      r++;
      k_ap_done = (r == done_at);
      tick();
      k_ap_done = 1'b0;
    end
    k_dmem_ce0 = 1'b0; k_dmem_we0 = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_at_cycle", 32'(r), 32'(exp_cyc));
    chk("rsp_status", 32'(rsp_status), 32'(exp_st));
    chk("rsp_cycles", rsp_cycles, 32'(exp_cyc));
    chk("rsp_krst", 32'(k_ap_rst), 32'd1);
    chk("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
    if (host_block) begin
      chk("resp_gnt", 32'(h_dmem_gnt), 32'd1);
      h_dmem_req = 1'b0; h_dmem_we = 1'b0;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    ap_rst = 1'b1; cmd_valid = 1'b0; cmd_timeout = '0; rsp_ready = 1'b0;
    k_ap_done = 1'b0; k_ap_idle = 1'b1;
    k_dmem_address0 = '0; k_dmem_ce0 = 1'b0; k_dmem_we0 = 1'b0; k_dmem_d0 = '0;
    h_dmem_req = 1'b0; h_dmem_we = 1'b0; h_dmem_addr = '0; h_dmem_d = '0;
    repeat (3) tick();
    ap_rst = 1'b0;

    // reset values
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_rsp_cycles", rsp_cycles, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_kstart", 32'(k_ap_start), 32'd0);
    chk("rst_krst", 32'(k_ap_rst), 32'd1);
    chk("rst_rvalid", 32'(h_dmem_rvalid), 32'd0);
    h_dmem_req = 1'b1; #1;
    chk("rst_gnt", 32'(h_dmem_gnt), 32'd1);

    // host write then read in IDLE
    h_dmem_we = 1'b1; h_dmem_addr = 5'd3; h_dmem_d = 32'hDEAD_BEEF; #1;
    chk("hw_ce", 32'(dmem_ce0), 32'd1);
    chk("hw_addr", 32'(dmem_address0), 32'd3);
    tick();
    chk("hw_rvalid", 32'(h_dmem_rvalid), 32'd0);
    h_dmem_we = 1'b0;
    tick();
    h_dmem_req = 1'b0;
    chk("hr_rvalid", 32'(h_dmem_rvalid), 32'd1);
    chk("hr_q", h_dmem_q, 32'hDEAD_BEEF);
    tick();
    chk("hr_rvalid_drop", 32'(h_dmem_rvalid), 32'd0);

    // normal run: done in RUN cycle 10, host held off during RUN
    run_cmd(16'd0, 10, 2'b00, 10, 1'b1);
    // backpressure: response held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_status", 32'(rsp_status), 32'd0);
      chk("bp_cycles", rsp_cycles, 32'd10);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    finish_rsp();

    // timeout at 5, then done coinciding with timeout (done wins)
    run_cmd(16'd5, 0, 2'b01, 5, 1'b0);
    finish_rsp();
    run_cmd(16'd5, 5, 2'b00, 5, 1'b0);
    finish_rsp();

    // mid-run reset in RUN cycle 4
    cmd_valid = 1'b1; cmd_timeout = 16'd0;
    tick();
    cmd_valid = 1'b0;
    repeat (SC + 3) tick();
    chk("mr_busy_before", 32'(busy), 32'd1);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mr_krst", 32'(k_ap_rst), 32'd1);
    chk("mr_cycles", rsp_cycles, 32'd0);
    repeat (3) tick();
    chk("mr_no_rsp", 32'(rsp_valid), 32'd0);

    // reset drops a pending rvalid
    h_dmem_req = 1'b1; h_dmem_we = 1'b0; ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0; h_dmem_req = 1'b0;
    chk("rst_drop_rvalid", 32'(h_dmem_rvalid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_run_ctrl.md
# kernel_run_ctrl

Launch sequencer and data-memory port arbiter for one `riscv_kernel` instance.
- Accepts a run command from the host side.
- Pulses the kernel start/reset.
- Counts execution cycles until the kernel signals done or a programmable timeout expires.
- Returns a status/cycle-count response.
- Owns the physical single-port dmem: the host preloads and reads back dmem while the kernel is parked, and the kernel owns it while running.

## Interface
Parameters:
- `START_CYCLES`, 2: cycles `k_ap_start` is held high (the kernel treats start as reset); legal range 1..255
- `TIMEOUT_W`, 16: width of the command timeout field
- `AddressWidth_dmem`, 5: dmem word address width
- `DataWidth`, 32: dmem data width

Ports:
- `ap_clk` in 1: clock; the only clock in the block
- `ap_rst` in 1: reset, synchronous, active-high
- `cmd_valid` in 1 / `cmd_ready` out 1: run-command handshake
- `cmd_timeout` in TIMEOUT_W: maximum RUN cycles; 0 = no timeout
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake
- `rsp_status` out 2: 2'b00 done, 2'b01 timeout
- `rsp_cycles` out 32: RUN cycles consumed
- `busy` out 1: state is START or RUN
- `k_ap_start` out 1, `k_ap_rst` out 1: drive the kernel's start and reset inputs
- `k_ap_done` in 1, `k_ap_idle` in 1: from the kernel; idle is informational only
- `k_dmem_address0` in AddressWidth_dmem, `k_dmem_ce0` in 1, `k_dmem_we0` in 1, `k_dmem_d0` in DataWidth: kernel dmem request
- `k_dmem_q0` out DataWidth: kernel dmem read data
- `h_dmem_req` in 1, `h_dmem_we` in 1, `h_dmem_addr` in AddressWidth_dmem, `h_dmem_d` in DataWidth: host dmem request
- `h_dmem_gnt` out 1, `h_dmem_rvalid` out 1, `h_dmem_q` out DataWidth: host dmem grant, read-valid and read data
- `dmem_address0` out, `dmem_ce0` out, `dmem_we0` out, `dmem_d0` out, `dmem_q0` in: physical dmem; 1-cycle read latency

## Operation
States and transitions:
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_timeout`, clear the cycle counter, go to START.
- START:
  - `k_ap_start`=1 for exactly START_CYCLES cycles, counted by an internal counter.
  - `k_ap_done` is ignored.
  - Then go to RUN.
- RUN:
  - `k_ap_start`=0 and `k_ap_rst`=0.
  - The counter increments each RUN cycle and saturates at 0xFFFF_FFFF. Its value in the first RUN cycle is 1.
  - `k_ap_done`=1: go to RESP with status 00 and `rsp_cycles` = counter value in that cycle.
  - Else, if the timeout is nonzero and counter == timeout: go to RESP with status 01.
  - Done and timeout in the same cycle: done wins.
- RESP:
  - `rsp_valid`=1; `rsp_status` and `rsp_cycles` are stable.
  - On `rsp_ready`: go to IDLE.

Kernel control:
- `k_ap_rst`=1 in IDLE and RESP, which parks the kernel so it cannot fetch or store.
- `k_ap_rst`=0 in START and RUN.

Dmem arbitration:
- Host window is state ∈ {IDLE, RESP}. In that window, `h_dmem_gnt` = `h_dmem_req` (combinational); otherwise it is 0.
- When granted, the physical port carries the host request: `dmem_address0`=`h_dmem_addr`, `dmem_we0`=`h_dmem_we`, `dmem_d0`=`h_dmem_d`, `dmem_ce0`=1.
- When not granted, the physical port passes the kernel signals through unchanged.
- `k_ap_start`/`k_ap_rst` keep the kernel's stores harmless during host ownership.
- `dmem_q0` is fanned out to both `k_dmem_q0` and `h_dmem_q`.
- `h_dmem_rvalid` is registered: it is 1 in the cycle after a granted read (`gnt & ~we`).
- A host request is never granted in START or RUN; the host must hold `req` until the window opens.

Reset:
- `ap_rst` at any time, including mid-RUN: next state IDLE, counters cleared, any pending rvalid dropped.

## Timing
Reset values (cycle after `ap_rst`):
- `cmd_ready`=1, `rsp_valid`=0, `rsp_status`=0, `rsp_cycles`=0, `busy`=0.
- `k_ap_start`=0, `k_ap_rst`=1.
- `h_dmem_gnt`=`h_dmem_req`, `h_dmem_rvalid`=0.

Cycle relationships:
- Command accepted in cycle T: START covers T+1..T+START_CYCLES; RUN begins at T+START_CYCLES+1.
- Done seen in cycle R: `rsp_valid`=1 from R+1; `k_ap_rst`=1 from R+1.
- RESP→IDLE takes 1 cycle after the `rsp_ready` handshake. A new command is accepted at the earliest 1 cycle after that handshake.
- All outputs except `h_dmem_gnt` and the physical dmem mux are registered.

## Test plan
- **Reset values:** assert `ap_rst` 3 cycles → all outputs at their reset values; `k_ap_rst`=1; `cmd_ready`=1.
- **Normal run:** START_CYCLES=2, command with timeout 0, kernel model raises `k_ap_done` in the 10th RUN cycle → `k_ap_start` high exactly 2 cycles; `rsp_status`=00; `rsp_cycles`=10; `k_ap_rst` reasserted the cycle after done.
- **Timeout:** `cmd_timeout`=5, done never raised → `rsp_status`=01, `rsp_cycles`=5. Same run with done in RUN cycle 5 → status 00, cycles 5.
- **Host dmem access in IDLE:** write addr 3 = 0xDEADBEEF, then read addr 3 → `h_dmem_rvalid`=1 one cycle after the read; `h_dmem_q`=0xDEADBEEF.
- **Host blocked during RUN:** `h_dmem_req` held during RUN → `h_dmem_gnt`=0 and the physical port mirrors the kernel's addr/we/d; gnt rises in the first RESP cycle.
- **Backpressure and mid-run reset:** `rsp_ready` low 3 cycles → rsp fields stable and `cmd_ready`=0. Separately, `ap_rst` pulsed in RUN cycle 4 → IDLE, no response issued, `busy`=0.
